if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 19 +
 rtl/if_fetch_icache_dm.sv | 54 +++++
 rtl/if_fetch.sv | 133 +++++++++++++
 tb/tb_if_fetch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, state encoding and reset default for the fetch unit
package if_fetch_pkg;

  localparam int INST_SIZE = 32;
  localparam int REG_SIZE  = 32;

  localparam logic [REG_SIZE-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_MISS  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [REG_SIZE-1:0] word_align(input logic [REG_SIZE-1:0] a);
    return {a[REG_SIZE-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_icache_dm.sv
// rtl/if_fetch_icache_dm.sv - one-word-per-line direct-mapped instruction cache
// Combinational read/hit at the fetch pointer, single registered fill port.
module icache_dm
  import if_fetch_pkg::*;
#(
  parameter int CACHE_LINES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_SIZE-1:2]   i_rd_addr,
  output logic                  o_rd_hit,
  output logic [INST_SIZE-1:0]  o_rd_data,
  input  logic                  i_wr_en,
  input  logic [REG_SIZE-1:2]   i_wr_addr,
  input  logic [INST_SIZE-1:0]  i_wr_data
);

  localparam int IDX_W = (CACHE_LINES > 1) ? $clog2(CACHE_LINES) : 1;
  localparam int TAG_W = REG_SIZE - 2 - IDX_W;

  logic [CACHE_LINES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag  [CACHE_LINES];
  logic [INST_SIZE-1:0]   r_data [CACHE_LINES];

  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic [TAG_W-1:0] w_wr_tag;

  assign w_rd_idx = i_rd_addr[2 +: IDX_W];
  assign w_rd_tag = i_rd_addr[REG_SIZE-1 -: TAG_W];
  assign w_wr_idx = i_wr_addr[2 +: IDX_W];
  assign w_wr_tag = i_wr_addr[REG_SIZE-1 -: TAG_W];

  // Only the valid bits need reset; tag/data are qualified by them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_hit  = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rd_data = r_data[w_rd_idx];

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: icache lookup, miss fill, redirect handling
// Pushes one instruction per cycle on hits; a miss holds a single memory request until done.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [REG_SIZE-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int                  CACHE_LINES = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  clear,
  input  logic [REG_SIZE-1:0]   target_pc,
  input  logic                  iq_wr_en,
  output logic                  inst_status,
  output logic [INST_SIZE-1:0]  inst,
  output logic [REG_SIZE-1:0]   pc,
  output logic                  mem_req,
  output logic [REG_SIZE-1:0]   mem_addr,
  input  logic                  mem_done,
  input  logic [INST_SIZE-1:0]  mem_data
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [REG_SIZE-1:0]   r_fpc;
  logic [REG_SIZE-1:0]   w_fpc_nxt;
  logic                  r_inst_status;
  logic                  w_inst_status_nxt;
  logic [INST_SIZE-1:0]  r_inst;
  logic [INST_SIZE-1:0]  w_inst_nxt;
  logic [REG_SIZE-1:0]   r_pc;
  logic [REG_SIZE-1:0]   w_pc_nxt;
  logic                  r_mem_req;
  logic                  w_mem_req_nxt;
  logic [REG_SIZE-1:0]   r_mem_addr;
  logic [REG_SIZE-1:0]   w_mem_addr_nxt;

  logic                  w_hit;
  logic [INST_SIZE-1:0]  w_line_data;
  logic                  w_fill;
  logic [REG_SIZE-1:0]   w_target;

  assign w_target = word_align(target_pc);

  icache_dm #(
    .CACHE_LINES (CACHE_LINES)
  ) u_icache (
    .i_clk     (clk_in),
    .i_rst_n   (rst_n_in),
    .i_rd_addr (r_fpc[REG_SIZE-1:2]),
    .o_rd_hit  (w_hit),
    .o_rd_data (w_line_data),
    .i_wr_en   (w_fill && rdy_in),
    .i_wr_addr (r_mem_addr[REG_SIZE-1:2]),
    .i_wr_data (mem_data)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_fpc_nxt         = r_fpc;
    w_inst_status_nxt = 1'b0;
    w_inst_nxt        = r_inst;
    w_pc_nxt          = r_pc;
    w_mem_req_nxt     = r_mem_req;
    w_mem_addr_nxt    = r_mem_addr;
    w_fill            = 1'b0;

    unique case (r_state)
      ST_FETCH: begin
        // A redirect wins over any hit or miss seen at the old pointer.
        if (clear) begin
          w_fpc_nxt = w_target;
        end else if (iq_wr_en) begin
          if (w_hit) begin
            w_inst_status_nxt = 1'b1;
            w_inst_nxt        = w_line_data;
            w_pc_nxt          = r_fpc;
            w_fpc_nxt         = r_fpc + 32'd4;
          end else begin
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = r_fpc;
            w_state_nxt    = ST_MISS;
          end
        end
      end
      ST_MISS, ST_DRAIN: begin
        // The fill address is the request address, so the returned word is
        // always cached even when a redirect made it useless for this pass.
        if (mem_done) begin
          w_fill        = 1'b1;
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = ST_FETCH;
        end else if (clear) begin
          w_state_nxt = ST_DRAIN;
        end
        if (clear) begin
          w_fpc_nxt = w_target;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= ST_FETCH;
      r_fpc         <= word_align(RESET_PC);
      r_inst_status <= 1'b0;
      r_inst        <= '0;
      r_pc          <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
    end else if (rdy_in) begin
      r_state       <= w_state_nxt;
      r_fpc         <= w_fpc_nxt;
      r_inst_status <= w_inst_status_nxt;
      r_inst        <= w_inst_nxt;
      r_pc          <= w_pc_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
    end
  end

  assign inst_status = r_inst_status;
  assign inst        = r_inst;
  assign pc          = r_pc;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch with a latency memory model
module tb_if_fetch;

  localparam int MEM_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_in, rdy_in, clear, iq_wr_en;
  logic [31:0] target_pc;
  logic        mem_done, mem_done2;
  logic [31:0] mem_data, mem_data2;

  logic        inst_status, mem_req, inst_status2, mem_req2;
  logic [31:0] inst, pc, mem_addr, inst2, pc2, mem_addr2;

  if_fetch #(.RESET_PC(32'h0000_0000), .CACHE_LINES(16)) dut (
    .clk_in(clk), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
    .target_pc(target_pc), .iq_wr_en(iq_wr_en), .inst_status(inst_status),
    .inst(inst), .pc(pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_data(mem_data)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8), .CACHE_LINES(8)) dut_w (
    .clk_in(clk), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
    .target_pc(target_pc), .iq_wr_en(iq_wr_en), .inst_status(inst_status2),
    .inst(inst2), .pc(pc2), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_done(mem_done2), .mem_data(mem_data2)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int cnt, cnt2;
  logic [31:0] seed;
  bit          const_data;

  logic        rdy_s, clear_s, iq_s, done_s, done2_s, req_prev;
  logic [31:0] tgt_s;
  bit          push, push2, req_rise, consumed;
  logic [31:0] push_pc, push_inst, push2_pc, push2_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (const_data) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  // One clock: sample what the DUTs saw at the edge, then advance the memory models.
  task automatic step();
    @(posedge clk);
    rdy_s = rdy_in; clear_s = clear; iq_s = iq_wr_en; tgt_s = target_pc;
    done_s = mem_done; done2_s = mem_done2; req_prev = mem_req;
    #1;
    cyc++;
    consumed = done_s && rdy_s;
    if (!rst_n_in || consumed) begin
      mem_done = 1'b0; cnt = 0;
    end else if (mem_req && rdy_s && !mem_done) begin
      cnt++;
      if (cnt >= MEM_LAT) begin mem_done = 1'b1; mem_data = mem_word(mem_addr); end
    end
    if (!rst_n_in || (done2_s && rdy_s)) begin
      mem_done2 = 1'b0; cnt2 = 0;
    end else if (mem_req2 && rdy_s && !mem_done2) begin
      cnt2++;
      if (cnt2 >= MEM_LAT) begin mem_done2 = 1'b1; mem_data2 = mem_word(mem_addr2); end
    end
    push = rdy_s && inst_status;  push_pc = pc;   push_inst = inst;
    push2 = rdy_s && inst_status2; push2_pc = pc2; push2_inst = inst2;
    req_rise = mem_req && !req_prev;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; iq_wr_en = 1'b0; target_pc = '0;
    step(); step();
    rst_n_in = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; iq_wr_en = 1'b0; target_pc = '0;
    step(); step();
    tests++; if (inst_status !== 1'b0) begin fails++; $display("FAIL reset_inst_status: got %b expected 0", inst_status); end
    tests++; if (inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h expected 00000000", inst); end
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h expected 00000000", mem_addr); end
    rst_n_in = 1'b1;
    step(); step();
    tests++; if (mem_req !== 1'b0 || inst_status !== 1'b0) begin
      fails++; $display("FAIL idle_no_wr_en: got req=%b push=%b expected 0 0", mem_req, inst_status);
    end
  endtask

  task automatic test_cold_fetch();
    int n = 0, rises = 0, done_cyc = -1, lat = -1;
    logic [31:0] exp_pc = 32'h0;
    const_data = 1'b1;
    do_reset();
    iq_wr_en = 1'b1;
    for (int i = 0; i < 100 && n < 3; i++) begin
      step();
      if (req_rise) rises++;
      if (consumed && done_cyc < 0) done_cyc = cyc - 1;
      if (push) begin
        tests++;
        if (push_pc !== exp_pc || push_inst !== 32'h13) begin
          fails++; $display("FAIL cold_push: got pc=%h inst=%h expected pc=%h inst=00000013", push_pc, push_inst, exp_pc);
        end
        if (n == 0) lat = cyc - done_cyc;
        n++; exp_pc += 32'd4;
        if (n == 3) begin clear = 1'b1; target_pc = 32'h0; end
      end
    end
    tests++; if (n != 3) begin fails++; $display("FAIL cold_push_count: got %0d expected 3", n); end
    tests++; if (rises != 3) begin fails++; $display("FAIL cold_miss_count: got %0d expected 3", rises); end
    tests++; if (lat != 2) begin fails++; $display("FAIL cold_done_to_push: got %0d expected 2", lat); end
    step();
    clear = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (!push || push_pc !== 32'(4 * i) || push_inst !== 32'h13 || mem_req !== 1'b0) begin
        fails++; $display("FAIL loop_hit_%0d: got push=%b pc=%h req=%b expected 1 %h 0", i, push, push_pc, mem_req, 32'(4 * i));
      end
    end
    iq_wr_en = 1'b0;
  endtask

  task automatic test_stall();
    int n = 0, rises = 0;
    clear = 1'b1; target_pc = 32'h0; iq_wr_en = 1'b0;
    step();
    clear = 1'b0; iq_wr_en = 1'b1;
    step();
    tests++; if (!push || push_pc !== 32'h0) begin fails++; $display("FAIL stall_pre: got push=%b pc=%h expected 1 00000000", push, push_pc); end
    iq_wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (push) n++;
      if (req_rise) rises++;
    end
    tests++; if (n != 0 || rises != 0) begin fails++; $display("FAIL stall_quiet: got pushes=%0d reqs=%0d expected 0 0", n, rises); end
    iq_wr_en = 1'b1;
    step();
    tests++; if (!push || push_pc !== 32'h4) begin fails++; $display("FAIL stall_resume: got push=%b pc=%h expected 1 00000004", push, push_pc); end
    iq_wr_en = 1'b0;
  endtask

  task automatic test_clear_during_miss();
    logic [31:0] exp_q[$];
    int n = 0, hold_bad = 0, rises = 0;
    bit cleared = 0, released = 0, done_loop = 0;
    exp_q = '{32'h0, 32'h4, 32'h100};
    const_data = 1'b0;
    do_reset();
    iq_wr_en = 1'b1;
    for (int i = 0; i < 200 && !done_loop; i++) begin
      step();
      if (clear) clear = 1'b0;
      if (cleared && !released) begin
        if (consumed) released = 1;
        else if (mem_req !== 1'b1 || mem_addr !== 32'h8) hold_bad++;
      end
      if (push) begin
        tests++;
        if (n >= 3 || push_pc !== exp_q[n] || push_inst !== mem_word(push_pc)) begin
          fails++; $display("FAIL redirect_push_%0d: got pc=%h inst=%h expected pc=%h", n, push_pc, push_inst, (n < 3) ? exp_q[n] : 32'hx);
        end
        if (push_pc === 32'h100) done_loop = 1;
        n++;
      end
      if (!cleared && mem_req && mem_addr === 32'h8) begin
        clear = 1'b1; target_pc = 32'h100; cleared = 1;
      end
    end
    tests++; if (!done_loop) begin fails++; $display("FAIL redirect_timeout: got pushes=%0d expected push of 00000100", n); end
    tests++; if (hold_bad != 0 || !released) begin fails++; $display("FAIL redirect_req_hold: got bad=%0d released=%b expected 0 1", hold_bad, released); end
    clear = 1'b1; target_pc = 32'h8;
    step();
    if (req_rise) rises++;
    clear = 1'b0;
    step();
    if (req_rise) rises++;
    tests++;
    if (!push || push_pc !== 32'h8 || push_inst !== mem_word(32'h8) || rises != 0) begin
      fails++; $display("FAIL drain_filled_line: got push=%b pc=%h inst=%h reqs=%0d expected 1 00000008 %h 0", push, push_pc, push_inst, rises, mem_word(32'h8));
    end
  endtask

  task automatic test_rdy_freeze();
    bit got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (req_rise) got = 1;
    end
    tests++; if (!got || mem_addr !== 32'hC) begin fails++; $display("FAIL freeze_miss_start: got seen=%b addr=%h expected 1 0000000c", got, mem_addr); end
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'hC || inst_status !== 1'b0 || pc !== 32'h8 || inst !== mem_word(32'h8) || mem_done !== 1'b0) begin
        fails++; $display("FAIL freeze_hold_%0d: got req=%b addr=%h st=%b pc=%h inst=%h", i, mem_req, mem_addr, inst_status, pc, inst);
      end
    end
    rdy_in = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (push) got = 1;
    end
    tests++;
    if (!got || push_pc !== 32'hC || push_inst !== mem_word(32'hC)) begin
      fails++; $display("FAIL freeze_resume: got push=%b pc=%h inst=%h expected 1 0000000c %h", got, push_pc, push_inst, mem_word(32'hC));
    end
    iq_wr_en = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] resident [int];
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] req_addr = 32'h0;
    int npush = 0, nreq = 0;
    const_data = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rdy_in    = ($urandom_range(0, 9) != 0);
      iq_wr_en  = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 24) == 0);
      target_pc = ($urandom_range(0, 1) ? 32'h400 : 32'h0) + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      step();
      if (consumed) resident[int'(req_addr[5:2])] = req_addr;
      if (push) begin
        tests++; npush++;
        if (!iq_s || (clear_s && rdy_s) || push_pc !== exp_pc || push_inst !== mem_word(exp_pc) ||
            !resident.exists(int'(exp_pc[5:2])) || resident[int'(exp_pc[5:2])] !== exp_pc) begin
          fails++; $display("FAIL rand_push: got pc=%h inst=%h expected pc=%h inst=%h (cycle %0d)", push_pc, push_inst, exp_pc, mem_word(exp_pc), cyc);
        end
        exp_pc += 32'd4;
      end
      if (req_rise) begin
        tests++; nreq++; req_addr = mem_addr;
        if (mem_addr !== exp_pc || (clear_s && rdy_s) ||
            (resident.exists(int'(exp_pc[5:2])) && resident[int'(exp_pc[5:2])] === exp_pc)) begin
          fails++; $display("FAIL rand_req: got addr=%h expected addr=%h for a true miss (cycle %0d)", mem_addr, exp_pc, cyc);
        end
      end
      if (clear_s && rdy_s) exp_pc = tgt_s & ~32'd3;
    end
    tests++; if (npush < 50 || nreq < 5) begin fails++; $display("FAIL rand_activity: got pushes=%0d reqs=%0d expected >=50 >=5", npush, nreq); end
    rdy_in = 1'b1; clear = 1'b0; iq_wr_en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_q[$];
    int n = 0;
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    const_data = 1'b0;
    do_reset();
    iq_wr_en = 1'b1;
    for (int i = 0; i < 100 && n < 3; i++) begin
      step();
      if (push2) begin
        tests++;
        if (push2_pc !== exp_q[n] || push2_inst !== mem_word(exp_q[n])) begin
          fails++; $display("FAIL wrap_push_%0d: got pc=%h inst=%h expected pc=%h inst=%h", n, push2_pc, push2_inst, exp_q[n], mem_word(exp_q[n]));
        end
        n++;
      end
    end
    tests++; if (n != 3) begin fails++; $display("FAIL wrap_push_count: got %0d expected 3", n); end
    iq_wr_en = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; iq_wr_en = 1'b0; target_pc = '0;
    mem_done = 1'b0; mem_done2 = 1'b0; mem_data = '0; mem_data2 = '0;
    cnt = 0; cnt2 = 0; const_data = 1'b1;
    seed = $urandom;
    test_reset();
    test_cold_fetch();
    test_back_to_back();
    test_stall();
    test_clear_during_miss();
    test_rdy_freeze();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout at cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
